// File: rtl/topk_pkg.sv
// Shared types and helpers for the top-3 frame scheduler and its tracker.
package topk_pkg;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_ID_W   = 4;
  localparam int MAX_CNT_W  = 32;

  typedef enum logic [1:0] {IDLE, STREAM, RESULT} state_t;

  // Widths are the supported maxima; users slice down to their own parameters.
  typedef struct packed {
    logic [MAX_ID_W-1:0]   id;
    logic [MAX_DATA_W-1:0] top0;
    logic [MAX_DATA_W-1:0] top1;
    logic [MAX_DATA_W-1:0] top2;
    logic [MAX_CNT_W-1:0]  count;
    logic                  sat;
  } result_t;

  // Most negative two's-complement value of width w, right-aligned.
  function automatic logic [MAX_DATA_W-1:0] min_val(input int unsigned w);
    return MAX_DATA_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/top3_tracker.sv
// Running signed top-3 of a sample stream with a saturating sample counter.
module top3_tracker
  import topk_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic signed [DATA_W-1:0] top0,
  output logic signed [DATA_W-1:0] top1,
  output logic signed [DATA_W-1:0] top2,
  output logic [CNT_W-1:0]         count,
  output logic                     sat
);

  localparam logic [MAX_DATA_W-1:0] MIN_FULL = min_val(DATA_W);
  localparam logic signed [DATA_W-1:0] MIN = MIN_FULL[DATA_W-1:0];

  logic signed [DATA_W-1:0] r_top0, r_top1, r_top2;
  logic [CNT_W-1:0]         r_count;
  logic                     r_sat;

  // Strict compares keep duplicates: an equal value falls to the next slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_top0  <= MIN;
      r_top1  <= MIN;
      r_top2  <= MIN;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (clear) begin
      r_top0  <= MIN;
      r_top1  <= MIN;
      r_top2  <= MIN;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (in_valid) begin
      if (in_data > r_top0) begin
        r_top2 <= r_top1;
        r_top1 <= r_top0;
        r_top0 <= in_data;
      end else if (in_data > r_top1) begin
        r_top2 <= r_top1;
        r_top1 <= in_data;
      end else if (in_data > r_top2) begin
        r_top2 <= in_data;
      end
      if (&r_count) r_sat   <= 1'b1;
      else          r_count <= r_count + 1'b1;
    end
  end

  assign top0  = r_top0;
  assign top1  = r_top1;
  assign top2  = r_top2;
  assign count = r_count;
  assign sat   = r_sat;

endmodule

// File: rtl/topk_frame_scheduler.sv
// Round-robin frame arbiter feeding one shared top-3 tracker; returns per-frame results.
module topk_frame_scheduler
  import topk_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ID_W-1:0]         res_id,
  output logic [DATA_W-1:0]       res_top0,
  output logic [DATA_W-1:0]       res_top1,
  output logic [DATA_W-1:0]       res_top2,
  output logic [CNT_W-1:0]        res_count,
  output logic                    res_sat
);

  state_t            r_state, w_next;
  logic [ID_W-1:0]   r_grant, r_rr_ptr, w_sel;
  logic              w_any, w_hs, w_last, w_clear;
  logic [DATA_W-1:0] w_data;

  assign w_any   = |req_valid;
  assign w_data  = req_data[r_grant*DATA_W +: DATA_W];
  assign w_last  = req_last[r_grant];
  assign w_hs    = (r_state == STREAM) && req_valid[r_grant];
  assign w_clear = (r_state == IDLE) && w_any;

  // Scan from the farthest offset down so the nearest requester at/after rr_ptr wins.
  always_comb begin : arb
    logic [ID_W-1:0] v_i;
    w_sel = r_rr_ptr;
    v_i   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      v_i = ID_W'((32'(r_rr_ptr) + 32'(k)) % N_REQ);
      if (req_valid[v_i]) w_sel = v_i;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    res_valid = 1'b0;
    unique case (r_state)
      IDLE:   if (w_any) w_next = STREAM;
      STREAM: begin
        req_ready[r_grant] = 1'b1;
        if (w_hs && w_last) w_next = RESULT;
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_next;
      if (w_clear) r_grant <= w_sel;
      if (r_state == RESULT && res_ready)
        r_rr_ptr <= (r_grant == ID_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
    end
  end

  assign res_id = r_grant;

  top3_tracker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_trk (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_clear),
    .in_valid (w_hs),
    .in_data  (w_data),
    .top0     (res_top0),
    .top1     (res_top1),
    .top2     (res_top2),
    .count    (res_count),
    .sat      (res_sat)
  );

endmodule

// File: tb/tb_topk_frame_scheduler.sv
// Scoreboard bench: directed frames into a default DUT and a 4-bit-counter twin on the same stimulus.
module tb_topk_frame_scheduler;
  import topk_pkg::*;

  localparam int N = 4;
  localparam int W = 32;
  localparam int MINI = int'(32'h8000_0000);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0]   req_valid, req_last;
  logic [N*W-1:0] req_data;
  logic           res_ready;

  logic [N-1:0] req_ready, s_req_ready;
  logic         res_valid, s_res_valid;
  logic [1:0]   res_id, s_res_id;
  logic [W-1:0] res_top0, res_top1, res_top2, s_res_top0, s_res_top1, s_res_top2;
  logic [7:0]   res_count;
  logic [3:0]   s_res_count;
  logic         res_sat, s_res_sat;

  topk_frame_scheduler #(.N_REQ(N), .DATA_W(W), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .res_valid(res_valid),
    .res_ready(res_ready), .res_id(res_id), .res_top0(res_top0),
    .res_top1(res_top1), .res_top2(res_top2), .res_count(res_count),
    .res_sat(res_sat));

  topk_frame_scheduler #(.N_REQ(N), .DATA_W(W), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(s_req_ready), .res_valid(s_res_valid),
    .res_ready(res_ready), .res_id(s_res_id), .res_top0(s_res_top0),
    .res_top1(s_res_top1), .res_top2(s_res_top2), .res_count(s_res_count),
    .res_sat(s_res_sat));

  always #5 clk = ~clk;

  typedef struct {
    result_t    r;
    logic [3:0] s_count;
    logic       s_sat;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  logic signed [W-1:0] fv [N][32];
  int fn [N];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int id, input int t0, input int t1, input int t2,
                      input int cnt, input logic sat, input int scnt, input logic ssat);
    exp_t e;
    e.r.id    = 4'(id);
    e.r.top0  = 64'(t0);
    e.r.top1  = 64'(t1);
    e.r.top2  = 64'(t2);
    e.r.count = 32'(cnt);
    e.r.sat   = sat;
    e.s_count = 4'(scnt);
    e.s_sat   = ssat;
    sb.push_back(e);
  endtask

  task automatic set_frame(input int id, input int n, input int base, input int step);
    fn[id] = n;
    for (int i = 0; i < n; i++) fv[id][i] = W'(base + i * step);
  endtask

  task automatic drop_req(input int id);
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
  endtask

  // Returns at the falling edge before the rising edge that takes the final beat.
  task automatic send_frame(input int id, input bit with_last);
    int b = 0;
    int guard = 0;
    while (b < fn[id] && guard < 300) begin
      @(negedge clk);
      req_valid[id]       = 1'b1;
      req_data[id*W +: W] = fv[id][b];
      req_last[id]        = with_last && (b == fn[id] - 1);
      if (req_ready[id]) b++;
      guard++;
    end
    check($sformatf("beats_accepted_r%0d", id), 32'(b), 32'(fn[id]));
  endtask

  task automatic wait_drain(input string tag);
    int g = 0;
    while (sb.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_id"},    32'(res_id), 32'd0);
    check({tag, "_top0"},      res_top0, 32'h8000_0000);
    check({tag, "_top1"},      res_top1, 32'h8000_0000);
    check({tag, "_top2"},      res_top2, 32'h8000_0000);
    check({tag, "_count"},     32'(res_count), 32'd0);
    check({tag, "_sat"},       32'(res_sat), 32'd0);
    check({tag, "_s_count"},   32'(s_res_count), 32'd0);
  endtask

  // Monitor: pops one expectation per accepted result.
  always @(negedge clk) begin : mon
    exp_t e;
    #1;
    if (!reset) begin
      check("ready_onehot",   32'($onehot0(req_ready)), 32'd1);
      check("s_ready_onehot", 32'($onehot0(s_req_ready)), 32'd1);
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got id %0d expected no result", res_id);
        end else begin
          e = sb.pop_front();
          check("res_id",      32'(res_id), 32'(e.r.id));
          check("res_top0",    res_top0, e.r.top0[31:0]);
          check("res_top1",    res_top1, e.r.top1[31:0]);
          check("res_top2",    res_top2, e.r.top2[31:0]);
          check("res_count",   32'(res_count), e.r.count);
          check("res_sat",     32'(res_sat), 32'(e.r.sat));
          check("s_res_valid", 32'(s_res_valid), 32'd1);
          check("s_res_id",    32'(s_res_id), 32'(e.r.id));
          check("s_res_top0",  s_res_top0, e.r.top0[31:0]);
          check("s_res_top1",  s_res_top1, e.r.top1[31:0]);
          check("s_res_top2",  s_res_top2, e.r.top2[31:0]);
          check("s_res_count", 32'(s_res_count), 32'(e.s_count));
          check("s_res_sat",   32'(s_res_sat), 32'(e.s_sat));
        end
      end
    end
  end

  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    res_ready = 1'b1;
    #2 reset = 1'b1;
    #1 check_reset("por");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Round robin: all four contend, requester 0 immediately re-requests.
    push(0, 3, -8, MINI, 2, 0, 2, 0);
    push(1, 4, -1, MINI, 2, 0, 2, 0);
    push(2, 100, 100, MINI, 2, 0, 2, 0);
    push(3, -2, -7, MINI, 2, 0, 2, 0);
    push(0, 6, 0, MINI, 2, 0, 2, 0);
    fork
      begin
        set_frame(0, 2, 3, -11);
        send_frame(0, 1);
        set_frame(0, 2, 0, 6);
        send_frame(0, 1);
        @(negedge clk); drop_req(0);
      end
      begin set_frame(1, 2, -1, 5);   send_frame(1, 1); @(negedge clk); drop_req(1); end
      begin set_frame(2, 2, 100, 0);  send_frame(2, 1); @(negedge clk); drop_req(2); end
      begin set_frame(3, 2, -7, 5);   send_frame(3, 1); @(negedge clk); drop_req(3); end
    join
    wait_drain("rr");

    // Single frame with duplicates and result latency.
    fn[2] = 5;
    fv[2][0] = 5; fv[2][1] = -3; fv[2][2] = 9; fv[2][3] = 9; fv[2][4] = 1;
    push(2, 9, 9, 5, 5, 0, 5, 0);
    send_frame(2, 1);
    check("lat_before_last", 32'(res_valid), 32'd0);
    @(negedge clk);
    drop_req(2);
    check("lat_after_last", 32'(res_valid), 32'd1);
    wait_drain("single");

    // Short frame leaves unused slots at MIN.
    set_frame(0, 1, 7, 0);
    push(0, 7, MINI, MINI, 1, 0, 1, 0);
    send_frame(0, 1);
    @(negedge clk); drop_req(0);
    wait_drain("short");

    // Result backpressure, then the next grant two cycles after acceptance.
    res_ready = 1'b0;
    fn[1] = 3; fv[1][0] = 2; fv[1][1] = 8; fv[1][2] = -4;
    set_frame(3, 1, -9, 0);
    push(1, 8, 2, -4, 3, 0, 3, 0);
    push(3, -9, MINI, MINI, 1, 0, 1, 0);
    fork
      begin
        send_frame(1, 1);
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (c == 0) drop_req(1);
          check("bp_res_valid", 32'(res_valid), 32'd1);
          check("bp_req_ready", 32'(req_ready), 32'd0);
          check("bp_res_id",    32'(res_id), 32'd1);
          check("bp_top0",      res_top0, 32'd8);
          check("bp_top1",      res_top1, 32'd2);
          check("bp_top2",      res_top2, 32'hFFFF_FFFC);
          check("bp_count",     32'(res_count), 32'd3);
        end
        @(negedge clk); res_ready = 1'b1;
        @(negedge clk); check("bp_idle_ready", 32'(req_ready), 32'd0);
        @(negedge clk); check("bp_next_grant", 32'(req_ready), 32'b1000);
      end
      begin send_frame(3, 1); @(negedge clk); drop_req(3); end
    join
    wait_drain("bp");

    // Reset mid-frame discards the partial frame.
    set_frame(1, 3, 50, 10);
    send_frame(1, 0);
    @(negedge clk);
    drop_req(1);
    reset = 1'b1;
    #1 check_reset("midreset");
    @(negedge clk);
    reset = 1'b0;
    set_frame(1, 6, -1, -1);
    push(1, -1, -2, -3, 6, 0, 6, 0);
    send_frame(1, 1);
    @(negedge clk); drop_req(1);
    wait_drain("restart");

    // Counter saturation on the 4-bit twin; the 8-bit DUT counts all 20.
    set_frame(2, 20, 1, 1);
    push(2, 20, 19, 18, 20, 0, 15, 1);
    send_frame(2, 1);
    @(negedge clk); drop_req(2);
    wait_drain("sat");

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/topk_frame_scheduler.md
# topk_frame_scheduler

Shares one signed top-3 tracker among N_REQ streaming requesters. Each requester submits a frame: a burst of samples ending in a `last` beat. The block grants whole frames round-robin and streams the granted frame through the tracker. It then returns the frame's three largest values, tagged with the requester ID, on a valid/ready result port. It sits between the per-channel sample sources and the statistics consumer.

## Interface
- N_REQ, default 4: number of requesters, range 2..16.
- DATA_W, default 32: sample width, signed two's complement.
- CNT_W, default 8: width of the per-frame sample counter.
- clk  in  1: clock.
- reset  in  1: asynchronous, active-high.
- req_valid  in  N_REQ: per-requester sample valid.
- req_data  in  N_REQ*DATA_W: per-requester sample. Requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  N_REQ: marks the final sample of the frame.
- req_ready  out  N_REQ: per-requester accept. At most one bit is set.
- res_valid  out  1: result available.
- res_ready  in  1: consumer accepts the result.
- res_id  out  max(1,$clog2(N_REQ)): index of the requester that owned the frame.
- res_top0 / res_top1 / res_top2  out  DATA_W each: largest, 2nd-largest and 3rd-largest values of the frame.
- res_count  out  CNT_W: number of samples in the frame, saturating.
- res_sat  out  1: res_count saturated during the frame.

## Operation
- FSM states: IDLE, STREAM, RESULT.
- **IDLE**
  - All req_ready are 0.
  - If any req_valid is set, select the first requester at or after rr_ptr, searching in increasing index order with wrap.
  - Register the selection as grant.
  - Clear the tracker: top0/1/2 = MIN = 1 followed by DATA_W-1 zeros. Clear count and sat.
  - Go to STREAM.
- **STREAM**
  - req_ready[grant] = 1; all other ready bits are 0.
  - A handshake is req_valid[grant] & req_ready[grant].
  - On each handshake the tracker inserts d, using signed compares evaluated top-down:
    - d > top0: top2 <= top1, top1 <= top0, top0 <= d.
    - else d > top1: top2 <= top1, top1 <= d.
    - else d > top2: top2 <= d.
    - Otherwise no change.
  - Duplicates are retained: a value equal to top0 lands in top1.
  - count increments on every handshake and saturates at 2^CNT_W-1. The handshake that would exceed the maximum sets sat.
  - A handshake carrying req_last[grant] goes to RESULT. That last sample is included in the result.
  - Non-granted requesters are ignored; their valid/data/last inputs must be held stable.
- **RESULT**
  - res_valid = 1. res_id = grant; res_top*, res_count and res_sat come from the tracker.
  - All req_ready are 0.
  - On res_ready: set rr_ptr = (grant+1) mod N_REQ and go to IDLE.
  - All result outputs are stable while res_valid=1 and res_ready=0.
- A frame of fewer than 3 samples leaves the unused slots at MIN. The consumer uses res_count to tell filled slots from empty ones. A genuine MIN sample never displaces anything.
- Reset, at any time including mid-frame:
  - State = IDLE, rr_ptr = 0, grant = 0.
  - Tracker = MIN, count = 0, sat = 0.
  - All outputs go low or MIN immediately.
  - A partial frame is discarded; its requester must restart the frame after reset.

## Timing
- Reset values:
  - req_ready = 0, res_valid = 0, res_id = 0.
  - res_top0/1/2 = MIN, res_count = 0, res_sat = 0.
- Arbitration takes 1 cycle: req_valid seen in IDLE at cycle t gives req_ready[grant] = 1 at t+1.
- Streaming throughput is 1 sample per cycle. req_ready is driven by registered state and grant only, never by req_valid.
- A last handshake at cycle t gives res_valid = 1 at t+1.
- A result accepted at cycle t puts the FSM in IDLE at t+1 and gives the next grant at t+2.
- Minimum frame overhead is 2 cycles beyond the sample count: 1 arbitration cycle plus at least 1 result cycle.
- A requester holding req_valid indefinitely cannot starve the others: the round-robin pointer moves past each completed grant.

## Structure
- Shared package `topk_pkg`:
  - state enum {IDLE, STREAM, RESULT}.
  - MIN-value function of DATA_W.
  - result struct {id, top0, top1, top2, count, sat}.
- Sub-module `top3_tracker`:
  - Ports: clk, reset, clear, in_valid, in_data, top0/1/2, count, sat.
  - Holds the insertion logic and counter.
  - The scheduler instantiates it once; the scheduler holds the FSM, the round-robin arbiter and the result port.

## Test plan
- **Single frame.** Requester 2 sends 5, -3, 9, 9, 1 with last on the final beat, res_ready=1. Expect res_id=2, top0=9, top1=9, top2=5, count=5, sat=0; res_valid asserts 1 cycle after the last beat.
- **Short frame.** Requester 0 sends the single sample 7 (last=1). Expect top0=7, top1=top2=0x8000_0000, count=1.
- **Round-robin fairness.** All 4 requesters continuously present 2-beat frames. Expect grant order 0,1,2,3,0 and no requester granted twice before the others.
- **Result backpressure.** Hold res_ready=0 for 10 cycles in RESULT. Expect outputs stable, req_ready=0 throughout, and the next grant 2 cycles after res_ready rises.
- **Reset mid-frame.** Reset after 3 of 6 beats of requester 1. Expect all outputs at reset values immediately. On restart, requester 1's full frame reports count=6 with no contamination from the discarded beats.
- **Saturation.** With CNT_W=4, send 20 beats of increasing values 1..20. Expect count=15, sat=1, top0=20, top1=19, top2=18.
